// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM generator: duty word format,
// clock and PWM frequency constants, the derived reset period, and the
// saturating magnitude helper used by each channel's compare.
package pwm_pkg;

    // Duty word width; the sign bit selects the bridge direction.
    localparam int DUTY_W = 24;

    // System clock and nominal PWM carrier frequency.
    localparam int CLK_FREQ = 32_000_000;
    localparam int PWM_FREQ = 20_000;

    // Carrier period in clock cycles that the block comes out of reset with.
    localparam int DEFAULT_PERIOD = CLK_FREQ / PWM_FREQ;

    // Signed duty: magnitude in clock cycles, negative means reverse drive.
    typedef logic signed [DUTY_W-1:0] duty_t;

    // Unsigned magnitude of a duty word.
    typedef logic [DUTY_W-1:0] mag_t;

    // Largest magnitude representable; the most negative duty saturates here.
    localparam mag_t MAG_MAX = mag_t'((2 ** (DUTY_W - 1)) - 1);

    // Most negative duty word, the one value whose negation overflows.
    localparam duty_t DUTY_MOST_NEG = duty_t'({1'b1, {(DUTY_W - 1){1'b0}}});

    // Absolute value of a duty word, saturating the most negative value so
    // that full reverse drive behaves like full forward drive.
    function automatic mag_t abs_sat(input duty_t duty);
        mag_t result;
        if (duty == DUTY_MOST_NEG) begin
            result = MAG_MAX;
        end else if (duty[DUTY_W-1]) begin
            result = mag_t'(-duty);
        end else begin
            result = mag_t'(duty);
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_multi_channel.sv
// One PWM channel of pwm_multi. Holds the pending and active duty words,
// compares the shared period counter against the active magnitude, and
// drives the registered PWM and direction outputs.
// Optional feature macro: PWM_DIR_DEADTIME_EN. When defined, a period that
// starts with a reversed duty sign keeps the output low for DEADTIME cycles
// (never longer than that period) so both bridge legs are off while the
// direction pin settles. When undefined, DEADTIME has no effect.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DEADTIME = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt,
    input  logic             wrap,
    input  logic [CNT_W-1:0] per_act,
    input  logic             wr_sel,
    input  duty_t            wr_duty,
    output logic             pwm_out,
    output logic             dir
);

    // The compare runs at the wider of the counter and duty widths so a
    // magnitude larger than any period is never truncated into a small one.
    localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

    duty_t            duty_pend;
    duty_t            duty_act;
    mag_t             mag;
    logic [CMP_W-1:0] cnt_ext;
    logic [CMP_W-1:0] mag_ext;
    logic             cmp_high;
    logic             force_low;
    logic             unused_per_act;

    assign mag      = abs_sat(duty_act);
    assign cnt_ext  = CMP_W'(cnt);
    assign mag_ext  = CMP_W'(mag);
    assign cmp_high = (cnt_ext < mag_ext);

    // The dead-time window is cut off by the wrap clear below, so the
    // channel never needs the period length itself.
    assign unused_per_act = ^per_act;

    // Pending duty takes every write; active duty copies pending at wrap so
    // a new duty only shows up from the start of the next period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_pend <= '0;
            duty_act  <= '0;
        end else begin
            if (wr_sel) begin
                duty_pend <= wr_duty;
            end
            if (wrap) begin
                duty_act <= duty_pend;
            end
        end
    end

`ifdef PWM_DIR_DEADTIME_EN
    localparam longint DT_MAX = (longint'(1) << CNT_W) - 1;
    localparam logic [CNT_W-1:0] DT_LOAD =
        (longint'(DEADTIME) > DT_MAX) ? '1 : CNT_W'(DEADTIME);

    logic [CNT_W-1:0] dt_cnt;
    logic             sign_change;

    assign sign_change = (duty_pend[DUTY_W-1] != duty_act[DUTY_W-1]);
    assign force_low   = (dt_cnt != '0);

    // Dead-time down-counter: armed at a wrap that reverses the sign, and
    // cleared at every other wrap so a window longer than a short period
    // can never leak into the following one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dt_cnt <= '0;
        end else if (wrap) begin
            dt_cnt <= sign_change ? DT_LOAD : '0;
        end else if (dt_cnt != '0) begin
            dt_cnt <= dt_cnt - CNT_W'(1);
        end
    end
`else
    logic unused_deadtime;

    assign force_low       = 1'b0;
    assign unused_deadtime = (DEADTIME != 0);
`endif

    // Registered outputs: the compare result (masked during dead time) and
    // the sign of the active duty, both one cycle behind the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= 1'b0;
            dir     <= 1'b0;
        end else begin
            pwm_out <= cmp_high && !force_low;
            dir     <= duty_act[DUTY_W-1];
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator for the motor-driver path. A single period
// counter is shared by CHANNELS signed-duty channels; duty and period
// writes are double-buffered and only take effect when the counter wraps,
// so the H-bridge never sees a truncated or stretched pulse.
// Optional feature macro: PWM_DIR_DEADTIME_EN (dead time on direction
// reversal, implemented inside pwm_channel).
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int CNT_W          = 16,
    parameter int DEFAULT_PERIOD = pwm_pkg::DEFAULT_PERIOD,
    parameter int DEADTIME       = 32,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  duty_t               wr_duty,
    input  logic                per_we,
    input  logic [CNT_W-1:0]    per_val,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] dir,
    output logic                period_start
);

    // Shortest legal period; anything smaller is clamped up to this.
    localparam logic [CNT_W-1:0] PER_MIN   = CNT_W'(2);
    localparam logic [CNT_W-1:0] PER_RESET = CNT_W'(DEFAULT_PERIOD);

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    per_act;
    logic [CNT_W-1:0]    per_pend;
    logic                wrap;
    logic [31:0]         wr_ch_ext;
    logic [CHANNELS-1:0] wr_sel;

    assign wrap      = (cnt == (per_act - CNT_W'(1)));
    assign wr_ch_ext = 32'(wr_ch);

    // Shared period counter: runs 0 .. per_act-1 and wraps. per_act only
    // changes at the wrap, so a shortened period can never be overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Period shadow registers: writes land in pending (clamped to the
    // minimum) and the active period picks them up at the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_pend <= PER_RESET;
            per_act  <= PER_RESET;
        end else begin
            if (per_we) begin
                per_pend <= (per_val < PER_MIN) ? PER_MIN : per_val;
            end
            if (wrap) begin
                per_act <= per_pend;
            end
        end
    end

    // Period marker, registered so it lines up with the first output cycle
    // of each period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_start <= 1'b0;
        end else begin
            period_start <= (cnt == '0);
        end
    end

    // Duty write decode: one-hot select of the addressed channel; an index
    // beyond the last channel selects nothing and the write is dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && (wr_ch_ext == 32'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .CNT_W    (CNT_W),
            .DEADTIME (DEADTIME)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .cnt     (cnt),
            .wrap    (wrap),
            .per_act (per_act),
            .wr_sel  (wr_sel[i]),
            .wr_duty (wr_duty),
            .pwm_out (pwm_out[i]),
            .dir     (dir[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi. Stimulus drives duty/period writes (directed
// cases followed by random traffic) and, at every period start, pushes the
// expected shape of that period into a scoreboard queue. A monitor measures
// each period the DUT actually produces and compares it with the queue.
// Honours PWM_DIR_DEADTIME_EN the same way the design does.
module tb_pwm_multi;
    import pwm_pkg::*;

    localparam int CHANNELS = 4;
    localparam int CNT_W    = 16;
    localparam int DEADTIME = 32;
    localparam int DEF_PER  = 1600;
`ifdef PWM_DIR_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic                wr_en;
    logic [1:0]          wr_ch;
    duty_t               wr_duty;
    logic                per_we;
    logic [CNT_W-1:0]    per_val;
    logic [CHANNELS-1:0] pwm_out;
    logic [CHANNELS-1:0] dir;
    logic                period_start;

    pwm_multi #(
        .CHANNELS       (CHANNELS),
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEF_PER),
        .DEADTIME       (DEADTIME)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .per_we       (per_we),
        .per_val      (per_val),
        .pwm_out      (pwm_out),
        .dir          (dir),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected shape of one period: its length, and per channel the first
    // high cycle (-1 if none), the number of high cycles and the direction.
    typedef struct packed {
        logic [31:0]                  len;
        logic [CHANNELS-1:0][31:0]    first;
        logic [CHANNELS-1:0][31:0]    count;
        logic [CHANNELS-1:0]          dirv;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: register contents as the rules describe them.
    int m_pend[CHANNELS];
    int m_act[CHANNELS];
    bit m_chg[CHANNELS];
    int m_pos;
    int m_per_act;
    int m_per_pend;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic int magOf(input int d);
        if (d == -8388608) return 8388607;
        if (d < 0) return -d;
        return d;
    endfunction

    function automatic int minOf(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic exp_t buildRecord();
        exp_t e;
        int hi_end;
        int dt;
        e = '0;
        e.len = 32'(m_per_act);
        for (int ch = 0; ch < CHANNELS; ch++) begin
            hi_end = minOf(magOf(m_act[ch]), m_per_act);
            dt = (DT_EN && m_chg[ch]) ? minOf(DEADTIME, m_per_act) : 0;
            if (hi_end > dt) begin
                e.first[ch] = 32'(dt);
                e.count[ch] = 32'(hi_end - dt);
            end else begin
                e.first[ch] = 32'hFFFF_FFFF;
                e.count[ch] = '0;
            end
            e.dirv[ch] = (m_act[ch] < 0);
        end
        return e;
    endfunction

    task automatic modelClear();
        for (int ch = 0; ch < CHANNELS; ch++) begin
            m_pend[ch] = 0;
            m_act[ch]  = 0;
            m_chg[ch]  = 1'b0;
        end
        m_pos      = 0;
        m_per_act  = DEF_PER;
        m_per_pend = DEF_PER;
    endtask

    // One clock edge of the reference model, using the inputs present at it.
    task automatic modelEdge();
        if (m_pos == 0) sb_q.push_back(buildRecord());
        if (m_pos == m_per_act - 1) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                m_chg[ch] = ((m_pend[ch] < 0) != (m_act[ch] < 0));
                m_act[ch] = m_pend[ch];
            end
            m_per_act = m_per_pend;
            m_pos = 0;
        end else begin
            m_pos++;
        end
        if (wr_en) m_pend[int'(wr_ch)] = int'(wr_duty);
        if (per_we) m_per_pend = (int'(per_val) < 2) ? 2 : int'(per_val);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic runIdle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic applyStimulus(input bit we, input int ch, input int duty, input bit pwe, input int pval);
        wr_en   = we;
        wr_ch   = 2'(ch);
        wr_duty = duty_t'(duty);
        per_we  = pwe;
        per_val = CNT_W'(pval);
        tick();
        wr_en   = 1'b0;
        per_we  = 1'b0;
        wr_duty = '0;
        per_val = '0;
    endtask

    task automatic waitWrap();
        for (int k = 0; k < 70000; k++) begin
            if (m_pos == m_per_act - 1) break;
            tick();
        end
    endtask

    task automatic doReset(input bit check_drain);
        if (check_drain) checkOutput("sb_drain_before_reset", longint'(sb_q.size() <= 1), 1);
        reset = 1'b1;
        #1;
        checkOutput("reset_pwm_out", pwm_out, 0);
        checkOutput("reset_dir", dir, 0);
        checkOutput("reset_period_start", period_start, 0);
        modelClear();
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int randDuty();
        int d;
        logic signed [23:0] r;
        case ($urandom_range(0, 5))
            0: d = 0;
            1: begin d = int'($urandom_range(0, 300)); if ($urandom_range(0, 1) == 1) d = -d; end
            2: d = -8388608;
            3: d = 8388607;
            4: begin d = int'($urandom_range(0, 2000)); if ($urandom_range(0, 1) == 1) d = -d; end
            default: begin r = 24'($urandom); d = int'(r); end
        endcase
        return d;
    endfunction

    // Monitor: measures every complete period between period_start pulses.
    bit mon_active = 1'b0;
    int mon_idx;
    int mon_pnum = 0;
    int mon_first[CHANNELS];
    int mon_last[CHANNELS];
    int mon_cnt[CHANNELS];
    bit mon_dir0[CHANNELS];
    bit mon_dirok[CHANNELS];

    task automatic finishPeriod();
        exp_t e;
        bit contiguous;
        checkOutput($sformatf("p%0d_sb_has_expected", mon_pnum), longint'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput($sformatf("p%0d_len", mon_pnum), mon_idx, int'(e.len));
            for (int ch = 0; ch < CHANNELS; ch++) begin
                contiguous = (mon_cnt[ch] == 0) || (mon_last[ch] - mon_first[ch] + 1 == mon_cnt[ch]);
                checkOutput($sformatf("p%0d_ch%0d_high_count", mon_pnum, ch), mon_cnt[ch], int'(e.count[ch]));
                checkOutput($sformatf("p%0d_ch%0d_first_high", mon_pnum, ch), mon_first[ch], int'(e.first[ch]));
                checkOutput($sformatf("p%0d_ch%0d_contiguous", mon_pnum, ch), contiguous, 1);
                checkOutput($sformatf("p%0d_ch%0d_dir", mon_pnum, ch), mon_dir0[ch], e.dirv[ch]);
                checkOutput($sformatf("p%0d_ch%0d_dir_stable", mon_pnum, ch), mon_dirok[ch], 1);
            end
        end
        mon_pnum++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
            end else begin
                if (period_start) begin
                    if (mon_active) finishPeriod();
                    mon_active = 1'b1;
                    mon_idx = 0;
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        mon_first[ch] = -1;
                        mon_last[ch]  = -1;
                        mon_cnt[ch]   = 0;
                        mon_dirok[ch] = 1'b1;
                    end
                end
                if (mon_active) begin
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        if (pwm_out[ch]) begin
                            if (mon_first[ch] < 0) mon_first[ch] = mon_idx;
                            mon_last[ch] = mon_idx;
                            mon_cnt[ch]++;
                        end
                        if (mon_idx == 0) mon_dir0[ch] = dir[ch];
                        else if (dir[ch] != mon_dir0[ch]) mon_dirok[ch] = 1'b0;
                    end
                    mon_idx++;
                end
            end
        end
    end

    initial begin
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_duty = '0;
        per_we  = 1'b0;
        per_val = '0;
        reset   = 1'b0;
        #2;
        doReset(1'b0);

        // Idle after reset: default period, everything low.
        runIdle(2 * DEF_PER + 10);

        // Mid-period write on ch0 only shows from the next period.
        runIdle(500);
        applyStimulus(1'b1, 0, 400, 1'b0, 0);
        runIdle(2 * DEF_PER + 10);

        // Reverse, over-range and most-negative duties.
        applyStimulus(1'b1, 1, -800, 1'b0, 0);
        applyStimulus(1'b1, 2, 5000, 1'b0, 0);
        applyStimulus(1'b1, 3, -8388608, 1'b0, 0);
        runIdle(2 * DEF_PER + 10);

        // Period write in the wrap cycle, then a too-small period.
        waitWrap();
        applyStimulus(1'b0, 0, 0, 1'b1, 100);
        runIdle(DEF_PER + 300);
        applyStimulus(1'b0, 0, 0, 1'b1, 1);
        runIdle(120);

        // Direction reversal on ch0 at the default period.
        applyStimulus(1'b0, 0, 0, 1'b1, DEF_PER);
        applyStimulus(1'b1, 0, 400, 1'b0, 0);
        runIdle(DEF_PER + 10);
        applyStimulus(1'b1, 0, -400, 1'b0, 0);
        runIdle(2 * DEF_PER + 10);

        // Random traffic with short periods, including same-cycle writes.
        applyStimulus(1'b0, 0, 0, 1'b1, int'($urandom_range(2, 250)));
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(1'b1, int'($urandom_range(0, CHANNELS - 1)), randDuty(),
                              ($urandom_range(0, 39) == 0), int'($urandom_range(0, 250)));
            end else if ($urandom_range(0, 39) == 0) begin
                applyStimulus(1'b0, 0, 0, 1'b1, int'($urandom_range(0, 250)));
            end else begin
                tick();
            end
        end

        // Reset in the middle of a high phase with a write still pending.
        applyStimulus(1'b0, 0, 0, 1'b1, DEF_PER);
        runIdle(300);
        applyStimulus(1'b1, 0, 1000, 1'b0, 0);
        runIdle(DEF_PER + 100);
        waitWrap();
        runIdle(100);
        applyStimulus(1'b1, 1, 50, 1'b0, 0);
        tick();
        #1;
        checkOutput("pre_reset_ch0_high", pwm_out[0], 1);
        doReset(1'b1);
        runIdle(2 * DEF_PER + 10);

        checkOutput("sb_drain_final", longint'(sb_q.size() <= 1), 1);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
